// File: rtl/screen_write_ctrl_if.sv
// screen_write_ctrl_if: host register write strobe in, screen RAM write port and status out
interface screen_write_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              reg_we;
    logic [3:0]        reg_addr;
    logic [7:0]        reg_wdata;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic              ram_wren;
    logic [ADDR_W-1:0] cursor;
    logic              busy;
    logic              ovf;
    modport master (
        output reg_we, reg_addr, reg_wdata,
        input  ram_waddr, ram_wdata, ram_wren, cursor, busy, ovf
    );
    modport slave (
        input  reg_we, reg_addr, reg_wdata,
        output ram_waddr, ram_wdata, ram_wren, cursor, busy, ovf
    );
endinterface

// File: rtl/screen_write_ctrl.sv
// screen_write_ctrl: host register decode, cursor, queued character writes and hardware screen fill
module screen_write_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int SCREEN_WORDS = 2400,
    parameter int FIFO_DEPTH   = 4
) (
    input logic                clk,
    input logic                rst,
    screen_write_ctrl_if.slave bus_io
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SCREEN_WORDS - 1);
    localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);
    typedef enum logic {IDLE, FILL} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d, fill_ptr_q, fill_ptr_d, ram_waddr_q, ram_waddr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d, fill_char_q, fill_char_d;
    logic              ram_wren_q, ram_wren_d, autoinc_q, autoinc_d;
    logic              ovf_q, ovf_d, fill_pend_q, fill_pend_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       cnt_q, cnt_d;
    logic [ADDR_W+7:0] fifo_q [FIFO_DEPTH];
    logic              we_ctrl, we_data, we_lo, we_hi, we_fch, full, empty, push, pop;
    assign we_ctrl = bus_io.reg_we && bus_io.reg_addr == 4'd0;
    assign we_data = bus_io.reg_we && bus_io.reg_addr == 4'd1;
    assign we_lo   = bus_io.reg_we && bus_io.reg_addr == 4'd2;
    assign we_hi   = bus_io.reg_we && bus_io.reg_addr == 4'd3;
    assign we_fch  = bus_io.reg_we && bus_io.reg_addr == 4'd4;
    assign full    = cnt_q == DEPTH;
    assign empty   = cnt_q == '0;
    assign push    = we_data && !full;
    // a pending fill holds off the FIFO so queued entries drain only after the fill
    assign pop     = state_q == IDLE && !fill_pend_q && !empty;
    always_comb begin
        state_d     = state_q;
        fill_ptr_d  = fill_ptr_q;
        fill_pend_d = fill_pend_q || (we_ctrl && bus_io.reg_wdata[1] && state_q == IDLE);
        ram_wren_d  = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        if (state_q == FILL) begin
            ram_wren_d  = 1'b1;
            ram_waddr_d = fill_ptr_q;
            ram_wdata_d = fill_char_q;
            fill_ptr_d  = fill_ptr_q + 1'b1;
            state_d     = fill_ptr_q == LAST ? IDLE : FILL;
        end else if (fill_pend_q) begin
            state_d     = FILL;
            fill_ptr_d  = '0;
            fill_pend_d = 1'b0;
        end else if (pop) begin
            ram_wren_d                 = 1'b1;
            {ram_waddr_d, ram_wdata_d} = fifo_q[rd_ptr_q];
        end
    end
    always_comb begin
        autoinc_d   = we_ctrl ? bus_io.reg_wdata[0] : autoinc_q;
        fill_char_d = we_fch ? bus_io.reg_wdata : fill_char_q;
        ovf_d       = (we_data && full) || (ovf_q && !(we_ctrl && bus_io.reg_wdata[2]));
        cnt_d       = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        cursor_d    = we_lo ? {cursor_q[ADDR_W-1:8], bus_io.reg_wdata} :
                      we_hi ? ADDR_W'({bus_io.reg_wdata, cursor_q[7:0]}) :
                      push && autoinc_q ? (cursor_q >= LAST ? '0 : cursor_q + 1'b1) : cursor_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cursor_q    <= '0;
            fill_ptr_q  <= '0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            fill_char_q <= 8'h20;
            autoinc_q   <= 1'b1;
            ovf_q       <= 1'b0;
            fill_pend_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            fill_ptr_q  <= fill_ptr_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
            fill_char_q <= fill_char_d;
            autoinc_q   <= autoinc_d;
            ovf_q       <= ovf_d;
            fill_pend_q <= fill_pend_d;
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            cnt_q       <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {cursor_q, bus_io.reg_wdata};
    end
    assign bus_io.ram_waddr = ram_waddr_q;
    assign bus_io.ram_wdata = ram_wdata_q;
    assign bus_io.ram_wren  = ram_wren_q;
    assign bus_io.cursor    = cursor_q;
    assign bus_io.busy      = state_q == FILL || fill_pend_q || !empty;
    assign bus_io.ovf       = ovf_q;
endmodule
